// File: rtl/ahb_pkg.sv
// Shared AHB-Lite constants, types and slave FSM states
// for the on-chip memory responder.
package ahb_pkg;

    typedef logic [31:0] word_t;
    typedef logic [31:0] addr_t;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DONE,
        ST_ERR1,
        ST_ERR2
    } slave_state_e;

endpackage

// File: rtl/ahb_word_ram.sv
// Word-wide memory array: one write port, one combinational
// read port, cleared by asynchronous reset.
module ahb_word_ram
    import ahb_pkg::*;
#(
    parameter int ADDR_BITS = 6
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] waddr,
    input  word_t                wdata,
    input  logic [ADDR_BITS-1:0] raddr,
    output word_t                rdata
);

    localparam int DEPTH = 1 << ADDR_BITS;

    word_t mem_q [DEPTH];

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/ahb_mem_slave.sv
// AHB-Lite memory slave: address-phase capture, wait-state
// insertion, two-cycle ERROR response and pipelined accept.
module ahb_mem_slave
    import ahb_pkg::*;
#(
    parameter int ADDR_BITS   = 6,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        hsel,
    input  logic [1:0]  htrans,
    input  logic [31:0] haddr,
    input  logic        hwrite,
    input  logic [31:0] hwdata,
    output logic [31:0] hrdata,
    output logic        hready,
    output logic        hresp
);

    localparam logic [3:0] WS_INIT =
        (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    slave_state_e state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [ADDR_BITS-1:0] addr_q;
    logic         write_q;
    logic         err_q;

    logic  active;
    logic  can_accept;
    logic  accept;
    logic  err_d;
    logic  ram_we;
    word_t ram_rdata;

    assign active = (htrans == HTRANS_NONSEQ) ||
                    (htrans == HTRANS_SEQ);

    assign can_accept = (state_q == ST_IDLE) ||
                        (state_q == ST_DONE) ||
                        (state_q == ST_ERR2);

    assign accept = can_accept && hsel && active;

    assign err_d = (haddr[1:0] != 2'b00) ||
                   (haddr[31:ADDR_BITS+2] != '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hready  = 1'b1;
        hresp   = HRESP_OKAY;
        ram_we  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
            end
            ST_WAIT: begin
                hready = 1'b0;
                if (cnt_q == 4'd0) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_DONE: begin
                ram_we  = write_q && !err_q;
                state_d = ST_IDLE;
            end
            ST_ERR1: begin
                hready  = 1'b0;
                hresp   = HRESP_ERROR;
                state_d = ST_ERR2;
            end
            ST_ERR2: begin
                hresp   = HRESP_ERROR;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // A new address phase overrides the return to IDLE
        if (accept) begin
            if (err_d) begin
                state_d = ST_ERR1;
            end else if (WAIT_STATES == 0) begin
                state_d = ST_DONE;
            end else begin
                state_d = ST_WAIT;
                cnt_d   = WS_INIT;
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            write_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                addr_q  <= haddr[ADDR_BITS+1:2];
                write_q <= hwrite;
                err_q   <= err_d;
            end
        end
    end

    ahb_word_ram #(
        .ADDR_BITS(ADDR_BITS)
    ) u_ram (
        .clk   (clk),
        .n_rst (n_rst),
        .we    (ram_we),
        .waddr (addr_q),
        .wdata (hwdata),
        .raddr (addr_q),
        .rdata (ram_rdata)
    );

    assign hrdata = (state_q == ST_DONE && !write_q)
                  ? ram_rdata : '0;

endmodule

// File: tb/tb_ahb_mem_slave.sv
// Directed bench: three slaves with WAIT_STATES 1, 0 and 3
// sharing the bus, selected one at a time via hsel.
module tb_ahb_mem_slave;

    logic        clk;
    logic        n_rst;
    logic [2:0]  hsel;
    logic [1:0]  htrans;
    logic [31:0] haddr;
    logic        hwrite;
    logic [31:0] hwdata;
    logic [31:0] hrdata [3];
    logic [2:0]  hready;
    logic [2:0]  hresp;

    int n_chk;
    int n_pass;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int WS = (g == 0) ? 1 : (g == 1) ? 0 : 3;
        ahb_mem_slave #(
            .ADDR_BITS   (6),
            .WAIT_STATES (WS)
        ) u_dut (
            .clk    (clk),
            .n_rst  (n_rst),
            .hsel   (hsel[g]),
            .htrans (htrans),
            .haddr  (haddr),
            .hwrite (hwrite),
            .hwdata (hwdata),
            .hrdata (hrdata[g]),
            .hready (hready[g]),
            .hresp  (hresp[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, want %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        hsel   = 3'b000;
        htrans = 2'b00;
    endtask

    task automatic addr_phase(input int d, input logic wr,
                              input logic [31:0] a);
        hsel    = 3'b000;
        hsel[d] = 1'b1;
        htrans  = 2'b10;
        haddr   = a;
        hwrite  = wr;
    endtask

    // Single transfer on slave d starting from an idle slave
    task automatic xfer(input string tag, input int d,
                        input logic wr, input logic [31:0] a,
                        input logic [31:0] wd, input int nwait,
                        input logic err, input logic [31:0] rd);
        addr_phase(d, wr, a);
        tick();
        bus_idle();
        hwdata = wd;
        if (err) begin
            chk({tag, ".e1rdy"}, 32'(hready[d]), 0);
            chk({tag, ".e1rsp"}, 32'(hresp[d]), 1);
            tick();
            chk({tag, ".e2rdy"}, 32'(hready[d]), 1);
            chk({tag, ".e2rsp"}, 32'(hresp[d]), 1);
            chk({tag, ".e2dat"}, hrdata[d], 0);
        end else begin
            for (int i = 0; i < nwait; i++) begin
                chk({tag, ".wrdy"}, 32'(hready[d]), 0);
                chk({tag, ".wrsp"}, 32'(hresp[d]), 0);
                tick();
            end
            chk({tag, ".rdy"}, 32'(hready[d]), 1);
            chk({tag, ".rsp"}, 32'(hresp[d]), 0);
            chk({tag, ".dat"}, hrdata[d], wr ? 32'h0 : rd);
        end
        tick();
        chk({tag, ".idle"}, 32'(hready[d]), 1);
        chk({tag, ".zero"}, hrdata[d], 0);
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        n_rst  = 1'b0;
        hsel   = 3'b000;
        htrans = 2'b00;
        haddr  = '0;
        hwrite = 1'b0;
        hwdata = '0;

        for (int c = 0; c < 3; c++) begin
            tick();
            for (int d = 0; d < 3; d++) begin
                chk("rst.rdy", 32'(hready[d]), 1);
                chk("rst.rsp", 32'(hresp[d]), 0);
                chk("rst.dat", hrdata[d], 0);
            end
        end
        n_rst = 1'b1;
        tick();
        chk("idle.rdy", 32'(hready[0]), 1);

        xfer("rd04", 0, 1'b0, 32'h04, 0, 1, 1'b0, 32'h0);

        xfer("wr10", 0, 1'b1, 32'h10, 32'hDEADBEEF,
             1, 1'b0, 0);
        xfer("rd10", 0, 1'b0, 32'h10, 0, 1, 1'b0,
             32'hDEADBEEF);

        // Pipelined write then read with no wait states
        addr_phase(1, 1'b1, 32'h0C);
        tick();
        chk("b2b.wrdy", 32'(hready[1]), 1);
        chk("b2b.wrsp", 32'(hresp[1]), 0);
        hwdata = 32'h12345678;
        addr_phase(1, 1'b0, 32'h0C);
        tick();
        bus_idle();
        hwdata = 32'h0;
        chk("b2b.rrdy", 32'(hready[1]), 1);
        chk("b2b.rdat", hrdata[1], 32'h12345678);
        tick();
        chk("b2b.irdy", 32'(hready[1]), 1);
        chk("b2b.izero", hrdata[1], 0);

        xfer("oow", 0, 1'b0, 32'h100, 0, 0, 1'b1, 0);
        xfer("rd00a", 0, 1'b0, 32'h00, 0, 1, 1'b0, 32'h0);
        xfer("unal", 0, 1'b1, 32'h02, 32'hFFFFFFFF,
             0, 1'b1, 0);
        xfer("rd00b", 0, 1'b0, 32'h00, 0, 1, 1'b0, 32'h0);
        xfer("oow3", 2, 1'b0, 32'h8000_0000, 0,
             0, 1'b1, 0);

        // Reset during the wait phase of a write
        addr_phase(2, 1'b1, 32'h20);
        tick();
        bus_idle();
        hwdata = 32'hAAAA5555;
        chk("mrst.w0", 32'(hready[2]), 0);
        tick();
        chk("mrst.w1", 32'(hready[2]), 0);
        #2;
        n_rst = 1'b0;
        #1;
        chk("mrst.rdy", 32'(hready[2]), 1);
        chk("mrst.rsp", 32'(hresp[2]), 0);
        tick();
        tick();
        n_rst = 1'b1;
        tick();
        xfer("rd20", 2, 1'b0, 32'h20, 0, 3, 1'b0, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/ahb_mem_slave.md
Name: ahb_mem_slave

Overview:
- AHB-Lite style responder: word-addressed on-chip memory that answers bus transfers from the image-processing AHB initiator.
- Decodes the address phase, inserts a configurable number of wait states, and commits writes or returns read data in the data phase.
- Signals ERROR for out-of-window or unaligned accesses.
- Used as the frame/scratch memory model in system sims, and as a synthesizable small SRAM slave.

Parameters:
- ADDR_BITS, 6, log2 of word depth (64 words); the window covers byte addresses 0 .. 4*2^ADDR_BITS-1.
- WAIT_STATES, 1, number of hready-low cycles inserted before each OKAY data-phase completion (0..15).

Ports:
- clk  input  1  system clock, rising edge
- n_rst  input  1  asynchronous active-low reset
- hsel  input  1  slave select from the external decoder
- htrans  input  2  transfer type (IDLE=00, BUSY=01, NONSEQ=10, SEQ=11)
- haddr  input  32  byte address, address phase
- hwrite  input  1  1=write, 0=read, address phase
- hwdata  input  32  write data, data phase
- hrdata  output  32  read data, valid when hready=1 in a read data phase
- hready  output  1  transfer-done / bus-ready
- hresp  output  1  0=OKAY, 1=ERROR

Behaviour:
- Reset (async, n_rst=0):
  - state=IDLE; hready=1, hresp=0, hrdata=0.
  - Wait counter=0; all memory words=0.
  - Reset asserted mid-transfer aborts it; no write is committed.
- Address-phase acceptance (rising edge) requires hsel=1, htrans[1]=1 and hready=1.
  - Registers addr_q=haddr, write_q=hwrite, err_q.
  - err_q=1 if haddr[1:0]!=0 or haddr[31:ADDR_BITS+2]!=0.
  - htrans IDLE/BUSY or hsel=0 -> nothing accepted; state unchanged if already IDLE.
- States: IDLE, WAIT, DONE, ERR1, ERR2.
- IDLE: hready=1, hresp=0. On acceptance:
  - err_q=1 -> ERR1.
  - WAIT_STATES=0 -> DONE.
  - otherwise -> WAIT with counter=WAIT_STATES-1.
- WAIT: hready=0, hresp=0. Counter decrements each cycle; at counter=0 -> DONE.
- DONE: hready=1, hresp=0.
  - Read: hrdata=mem[addr_q[ADDR_BITS+1:2]].
  - Write: mem[addr_q index] <= hwdata at the end of this cycle.
  - A new address phase may be accepted in this same cycle (pipelined back-to-back). Next state follows the IDLE rules for the new transfer; otherwise -> IDLE.
- ERR1: hready=0, hresp=1 -> ERR2.
- ERR2: hready=1, hresp=1. No memory write, hrdata=0. Back-to-back acceptance is allowed as in DONE.
- hrdata=0 in every cycle other than a read DONE cycle.
- Latency, OKAY transfer: data phase lasts WAIT_STATES+1 cycles. Error transfer: always 2 data-phase cycles, irrespective of WAIT_STATES.
- Read-after-write, same address, back-to-back: the read returns the newly written data. The write commits at the DONE edge, before the read's DONE cycle.
- Only 32-bit transfers; no hsize port; burst type is ignored. SEQ is treated as NONSEQ.
- Signals sampled while hready=0 are ignored. The initiator must hold its address-phase values stable; the slave never re-samples them.

Decomposition:
- Package ahb_pkg:
  - HTRANS_IDLE/BUSY/NONSEQ/SEQ constants
  - HRESP_OKAY/ERROR constants
  - slave state enum typedef
  - 32-bit word/address typedefs
- Sub-module ahb_word_ram:
  - 2^ADDR_BITS x 32 array, async reset to 0
  - one write port (we, waddr, wdata), one combinational read port (raddr, rdata)
- Top module holds the FSM, address-phase registers, wait counter and error decode.

Test Plan:
- Reset then idle: n_rst low 3 cycles, htrans=IDLE -> hready=1, hresp=0, hrdata=0 throughout; read of 0x04 later returns 0x00000000.
- Write/read, WAIT_STATES=1: write 0xDEADBEEF to 0x10, then read 0x10.
  - Each transfer: hready low exactly 1 cycle, then high.
  - Read DONE cycle shows hrdata=0xDEADBEEF, hresp=0.
- Back-to-back pipelined, WAIT_STATES=0: write 0x0C=0x12345678 immediately followed by read 0x0C -> hready stays 1 every cycle; read returns 0x12345678.
- Error, out of window: read 0x00000100 (ADDR_BITS=6) -> ERR1 (hready=0, hresp=1), then ERR2 (hready=1, hresp=1, hrdata=0). A following read of 0x00 is OKAY.
- Error, unaligned write to 0x02 with data 0xFFFFFFFF -> two-cycle ERROR; mem[0] remains 0.
- Mid-transfer reset, WAIT_STATES=3: pulse n_rst low during WAIT of a write to 0x20 -> hready=1 immediately; read of 0x20 afterwards returns 0x00000000.
